adma2_descriptor_fetch: RTL and testbench
=========================================

Name: adma2_descriptor_fetch

Overview:
- ADMA2 descriptor fetch and parse stage. Sits directly upstream of the SD host DMA transfer engine.
- Walks the 64-bit ADMA2 descriptor table in system memory, starting at Initial_ADMA_System_Address.
- Decodes each line (Valid/End/Int/Act), hands transfer descriptors to the engine and follows link descriptors.
- Raises sticky DMA_Interrupt, Transfer_complete and ADMA_Error flags; each flag is cleared by its ack_* strobe.

Parameters:
- DESC_BYTES, 8, address increment per descriptor line
- MAX_LINKS, 16, consecutive non-transfer descriptors allowed (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- Initial_ADMA_System_Address  in  64  descriptor table base
- ack_ADMA_System_Address_Register  in  1  pulse: load base into pointer; accepted only in ST_STOP
- start  in  1  pulse: begin walking from pointer; accepted only in ST_STOP
- mem_rd_req  out  1  descriptor read request, held until ack
- mem_rd_addr  out  64  read address, equals pointer
- mem_rd_ack  in  1  read data valid, one cycle
- mem_rd_data  in  64  descriptor line
- mem_rd_err  in  1  bus error, qualified by mem_rd_ack
- xfer_valid  out  1  transfer descriptor offered
- xfer_ready  in  1  engine accepts the offer
- xfer_addr  out  64  data address, zero-extended from desc[63:32]
- xfer_len  out  17  byte count, 1..65536
- xfer_last  out  1  End attribute of the offered descriptor
- xfer_done  in  1  pulse: engine finished the accepted transfer
- xfer_err  in  1  pulse: engine data error
- ADMA_System_Address_Register  out  64  current descriptor pointer
- ADMA_Error_State  out  2  00 ST_STOP, 01 ST_FDS, 11 ST_TFR (latched at error)
- DMA_Interrupt  out  1  sticky flag
- ack_DMA_Interrupt  in  1  clears DMA_Interrupt
- Transfer_complete  out  1  sticky flag
- ack_Transfer_complete  in  1  clears Transfer_complete
- ADMA_Error  out  1  sticky flag
- ack_ADMA_Error  in  1  clears ADMA_Error
- busy  out  1  high in any state other than STOP

Behaviour:
- Reset (async, reset_n=0): state STOP; pointer 0; mem_rd_req, xfer_valid, xfer_last 0; xfer_addr 0; xfer_len 0; all flags 0; ADMA_Error_State 00; busy 0. Reset mid-fetch or mid-transfer abandons the operation; no flag is set.
- Descriptor format: [0] Valid, [1] End, [2] Int, [5:4] Act (00 nop, 01 rsv, 10 tran, 11 link), [31:16] length with 0 meaning 65536, [63:32] address.
- States:
  - STOP: idle.
  - FETCH: mem_rd_req=1 with mem_rd_addr=pointer; stay until mem_rd_ack.
  - DECODE: one cycle.
  - OFFER: xfer_valid=1 until xfer_ready.
  - XFER: wait for xfer_done or xfer_err.
  - ERR: one cycle, then STOP.
- STOP -> FETCH on start.
- FETCH -> ERR on mem_rd_ack with mem_rd_err (state code 01). Otherwise FETCH -> DECODE, registering the line.
- DECODE:
  - Valid=0 -> ERR (01).
  - nop or rsv -> pointer += 8; if End, STOP with Transfer_complete; else FETCH.
  - tran -> OFFER, driving xfer_addr, xfer_len, xfer_last.
  - link -> pointer = {32'b0, addr}; addr[2:0] != 0 -> ERR (01); End set -> STOP with Transfer_complete; else FETCH.
- OFFER: outputs stable while xfer_valid=1 && xfer_ready=0. Handshake completes on the cycle both are high -> XFER.
- XFER:
  - xfer_err -> ERR (11).
  - xfer_done -> pointer += 8; Int sets DMA_Interrupt; End -> STOP with Transfer_complete; else FETCH.
  - xfer_done and xfer_err in the same cycle: error wins.
- Pointer arithmetic: 64-bit modulo 2^64; wrap from FFFF_FFFF_FFFF_FFF8 to 0 is silent.
- Int on a nop or link descriptor sets DMA_Interrupt when that descriptor is consumed.
- ERR sets ADMA_Error and latches ADMA_Error_State. The pointer keeps the failing descriptor address.
- Flags: set one cycle after the causing event. If set and ack occur in the same cycle, set wins. Ack with the flag already low has no effect.
- start or ack_ADMA_System_Address_Register outside STOP is ignored.

Optional Feature:
- ADMA_LINK_LIMIT_EN defined: a 5-bit counter counts consecutive nop/rsv/link descriptors and is cleared on each tran. If the counter reaches MAX_LINKS, the walk goes to ERR (01) and sets ADMA_Error, preventing infinite link loops.
- Undefined: no counter; link chains are unbounded.

Test Plan:
- Base 0x1000. Single tran desc {addr 0x2000, len 0x0200, End=1, Int=1, Valid=1}. Expect xfer_addr 0x2000, xfer_len 512, xfer_last 1. After xfer_done: Transfer_complete=1, DMA_Interrupt=1, pointer 0x1008, busy 0.
- tran len field 0 -> xfer_len 65536. Hold xfer_ready low 5 cycles -> xfer_valid and outputs stable all 5 cycles.
- Link at 0x1000 to 0x3000; tran+End at 0x3000. Expect second mem_rd_addr 0x3000 and completion. Link to 0x3004 -> ADMA_Error=1, ADMA_Error_State 01.
- Valid=0 line -> ADMA_Error=1, state 01, no xfer_valid. xfer_err during XFER -> state 11. ack_ADMA_Error with no new error -> flag cleared next cycle.
- Flag set and ack in the same cycle -> flag stays 1. reset_n low during FETCH -> all outputs 0 immediately.
- With ADMA_LINK_LIMIT_EN and MAX_LINKS=16: self-linking descriptor -> ADMA_Error after the 16th fetch. Without the macro: still fetching after 100 descriptors.

Source files
------------

// File: rtl/adma2_descriptor_fetch.sv
// ADMA2 descriptor fetch/parse stage: walks the descriptor table and hands transfer lines to the DMA engine.
// Optional macro ADMA_LINK_LIMIT_EN bounds runs of consecutive nop/rsv/link descriptors to MAX_LINKS.
module adma2_descriptor_fetch #(
    parameter int DESC_BYTES = 8,
    parameter int MAX_LINKS  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] Initial_ADMA_System_Address,
    input  logic        ack_ADMA_System_Address_Register,
    input  logic        start,
    output logic        mem_rd_req,
    output logic [63:0] mem_rd_addr,
    input  logic        mem_rd_ack,
    input  logic [63:0] mem_rd_data,
    input  logic        mem_rd_err,
    output logic        xfer_valid,
    input  logic        xfer_ready,
    output logic [63:0] xfer_addr,
    output logic [16:0] xfer_len,
    output logic        xfer_last,
    input  logic        xfer_done,
    input  logic        xfer_err,
    output logic [63:0] ADMA_System_Address_Register,
    output logic [1:0]  ADMA_Error_State,
    output logic        DMA_Interrupt,
    input  logic        ack_DMA_Interrupt,
    output logic        Transfer_complete,
    input  logic        ack_Transfer_complete,
    output logic        ADMA_Error,
    input  logic        ack_ADMA_Error,
    output logic        busy
);
    typedef enum logic [2:0] {ST_STOP, ST_FETCH, ST_DECODE, ST_OFFER, ST_XFER, ST_ERR} state_t;
    localparam logic [1:0] ACT_TRAN = 2'b10;
    localparam logic [1:0] ACT_LINK = 2'b11;
    localparam logic [1:0] ES_FDS   = 2'b01;
    localparam logic [1:0] ES_TFR   = 2'b11;

    state_t      state, state_n;
    logic [63:0] ptr, ptr_n, ptr_inc;
    logic        d_valid, d_end, d_int;
    logic [1:0]  d_act;
    logic [15:0] d_len;
    logic [31:0] d_addr;
    logic        load_xfer, set_int, set_tc, set_err, limit_hit;
    logic [1:0]  err_code;

    // Reserved attribute bits of the descriptor line carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{mem_rd_data[15:6], mem_rd_data[3]};

    assign ptr_inc     = ptr + 64'(DESC_BYTES);
    assign mem_rd_req  = (state == ST_FETCH);
    assign mem_rd_addr = ptr;
    assign xfer_valid  = (state == ST_OFFER);
    assign busy        = (state != ST_STOP);
    assign ADMA_System_Address_Register = ptr;

`ifdef ADMA_LINK_LIMIT_EN
    logic [4:0] link_cnt, link_cnt_n;
    logic [5:0] link_cnt_inc;

    assign link_cnt_inc = {1'b0, link_cnt} + 6'd1;
    assign limit_hit    = (link_cnt_inc >= 6'(MAX_LINKS));

    always_comb begin
        link_cnt_n = link_cnt;
        if (state == ST_STOP && start)
            link_cnt_n = '0;
        else if (state == ST_DECODE && d_valid)
            link_cnt_n = (d_act == ACT_TRAN) ? 5'd0 : link_cnt_inc[4:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) link_cnt <= '0;
        else          link_cnt <= link_cnt_n;
    end
`else
    localparam int unused_max_links = MAX_LINKS;
    assign limit_hit = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        load_xfer = 1'b0;
        set_int   = 1'b0;
        set_tc    = 1'b0;
        set_err   = 1'b0;
        err_code  = 2'b00;
        case (state)
            ST_STOP: begin
                if (ack_ADMA_System_Address_Register) ptr_n = Initial_ADMA_System_Address;
                if (start) state_n = ST_FETCH;
            end
            ST_FETCH: if (mem_rd_ack) begin
                if (mem_rd_err) begin
                    state_n = ST_ERR; set_err = 1'b1; err_code = ES_FDS;
                end else begin
                    state_n = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Errors leave the pointer on the offending line.
                if (!d_valid || (limit_hit && d_act != ACT_TRAN) ||
                    (d_act == ACT_LINK && d_addr[2:0] != 3'b000)) begin
                    state_n = ST_ERR; set_err = 1'b1; err_code = ES_FDS;
                end else if (d_act == ACT_TRAN) begin
                    state_n   = ST_OFFER;
                    load_xfer = 1'b1;
                end else begin
                    ptr_n   = (d_act == ACT_LINK) ? {32'b0, d_addr} : ptr_inc;
                    set_int = d_int;
                    set_tc  = d_end;
                    state_n = d_end ? ST_STOP : ST_FETCH;
                end
            end
            ST_OFFER: if (xfer_ready) state_n = ST_XFER;
            ST_XFER: begin
                if (xfer_err) begin
                    state_n = ST_ERR; set_err = 1'b1; err_code = ES_TFR;
                end else if (xfer_done) begin
                    ptr_n   = ptr_inc;
                    set_int = d_int;
                    set_tc  = d_end;
                    state_n = d_end ? ST_STOP : ST_FETCH;
                end
            end
            ST_ERR:  state_n = ST_STOP;
            default: state_n = ST_STOP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_STOP;
            ptr               <= '0;
            d_valid           <= 1'b0;
            d_end             <= 1'b0;
            d_int             <= 1'b0;
            d_act             <= 2'b00;
            d_len             <= '0;
            d_addr            <= '0;
            xfer_addr         <= '0;
            xfer_len          <= '0;
            xfer_last         <= 1'b0;
            ADMA_Error_State  <= 2'b00;
            DMA_Interrupt     <= 1'b0;
            Transfer_complete <= 1'b0;
            ADMA_Error        <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            if (state == ST_FETCH && mem_rd_ack) begin
                d_valid <= mem_rd_data[0];
                d_end   <= mem_rd_data[1];
                d_int   <= mem_rd_data[2];
                d_act   <= mem_rd_data[5:4];
                d_len   <= mem_rd_data[31:16];
                d_addr  <= mem_rd_data[63:32];
            end
            if (load_xfer) begin
                xfer_addr <= {32'b0, d_addr};
                xfer_len  <= (d_len == 16'd0) ? 17'h10000 : {1'b0, d_len};
                xfer_last <= d_end;
            end
            if (set_err) ADMA_Error_State <= err_code;
            // A set in the same cycle as its ack wins.
            DMA_Interrupt     <= set_int | (DMA_Interrupt & ~ack_DMA_Interrupt);
            Transfer_complete <= set_tc  | (Transfer_complete & ~ack_Transfer_complete);
            ADMA_Error        <= set_err | (ADMA_Error & ~ack_ADMA_Error);
        end
    end
endmodule

// File: tb/tb_adma2_descriptor_fetch.sv
// Bench for adma2_descriptor_fetch: vector table, directed corner cases and random descriptor chains
// checked against a table-walking reference model.
module tb_adma2_descriptor_fetch;
    localparam int MAX_LINKS = 16;

    typedef struct { logic [63:0] addr; logic [16:0] len; logic last; } offer_t;
    typedef struct {
        string       name;
        logic [63:0] base, line0, line1;
        bit          rd_err;
        int          hold;
        bit          exp_offer;
        logic [63:0] exp_addr;
        logic [16:0] exp_len;
        bit          exp_last, exp_tc, exp_int, exp_err;
        logic [1:0]  exp_es;
        logic [63:0] exp_ptr;
    } vec_t;

    logic        clk = 1'b0, reset_n = 1'b1;
    logic [63:0] base_addr = '0;
    logic        ack_base = 1'b0, start = 1'b0;
    logic        mem_rd_req, mem_rd_ack = 1'b0, mem_rd_err = 1'b0;
    logic [63:0] mem_rd_addr, mem_rd_data = '0;
    logic        xfer_valid, xfer_ready = 1'b0, xfer_last, xfer_done = 1'b0, xfer_err = 1'b0;
    logic [63:0] xfer_addr, ptr;
    logic [16:0] xfer_len;
    logic [1:0]  es;
    logic        dma_int, tc, adma_err, busy;
    logic        ack_int = 1'b0, ack_tc = 1'b0, ack_tc_eng = 1'b0, ack_err = 1'b0;

    logic [63:0] mem [logic [63:0]];
    logic [63:0] fetch_log[$], exp_fetch[$];
    offer_t      got[$], exp_offers[$];
    bit          mem_auto = 1'b1, err_en = 1'b0, eng_err = 1'b0, eng_done_too = 1'b0, ack_on_done = 1'b0;
    logic [63:0] err_addr = '0;
    int          hold_fixed = -1, unstable = 0;
    bit          e_tc, e_int, e_err;
    logic [1:0]  e_es;
    logic [63:0] e_ptr;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    adma2_descriptor_fetch dut (
        .clk(clk), .reset_n(reset_n),
        .Initial_ADMA_System_Address(base_addr),
        .ack_ADMA_System_Address_Register(ack_base), .start(start),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
        .mem_rd_data(mem_rd_data), .mem_rd_err(mem_rd_err),
        .xfer_valid(xfer_valid), .xfer_ready(xfer_ready), .xfer_addr(xfer_addr),
        .xfer_len(xfer_len), .xfer_last(xfer_last), .xfer_done(xfer_done), .xfer_err(xfer_err),
        .ADMA_System_Address_Register(ptr), .ADMA_Error_State(es),
        .DMA_Interrupt(dma_int), .ack_DMA_Interrupt(ack_int),
        .Transfer_complete(tc), .ack_Transfer_complete(ack_tc | ack_tc_eng),
        .ADMA_Error(adma_err), .ack_ADMA_Error(ack_err), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory slave: random latency, one-cycle ack.
    initial forever begin
        int d;
        @(negedge clk);
        if (mem_auto && mem_rd_req) begin
            d = $urandom_range(0, 3);
            repeat (d) @(negedge clk);
            if (mem_rd_req) begin
                mem_rd_data = mem.exists(mem_rd_addr) ? mem[mem_rd_addr] : 64'h0;
                mem_rd_err  = err_en && (mem_rd_addr == err_addr);
                mem_rd_ack  = 1'b1;
                fetch_log.push_back(mem_rd_addr);
                @(negedge clk);
                mem_rd_ack = 1'b0; mem_rd_err = 1'b0;
            end
        end
    end

    // DMA engine: holds ready low for a while, then finishes the transfer.
    initial forever begin
        int n;
        offer_t o;
        @(negedge clk);
        if (xfer_valid) begin
            o.addr = xfer_addr; o.len = xfer_len; o.last = xfer_last;
            n = (hold_fixed >= 0) ? hold_fixed : $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                if (!xfer_valid || xfer_addr !== o.addr || xfer_len !== o.len || xfer_last !== o.last)
                    unstable++;
            end
            xfer_ready = 1'b1;
            got.push_back(o);
            @(negedge clk);
            xfer_ready = 1'b0;
            n = $urandom_range(0, 4);
            repeat (n) @(negedge clk);
            xfer_err   = eng_err;
            xfer_done  = !eng_err || eng_done_too;
            ack_tc_eng = ack_on_done;
            @(negedge clk);
            xfer_err = 1'b0; xfer_done = 1'b0; ack_tc_eng = 1'b0;
        end
    end

    task automatic kick(input logic [63:0] b);
        got.delete(); fetch_log.delete(); unstable = 0;
        @(negedge clk);
        base_addr = b; ack_base = 1'b1; start = 1'b1;
        @(negedge clk);
        ack_base = 1'b0; start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int c = 0;
        while (busy && c < budget) begin @(negedge clk); c++; end
        if (busy) begin
            n_cmp++; n_bad++;
            $display("FAIL %s/timeout: busy still 1 after %0d cycles, expected 0", tag, budget);
        end
    endtask

    task automatic clear_flags(input string tag);
        @(negedge clk);
        ack_int = 1'b1; ack_tc = 1'b1; ack_err = 1'b1;
        @(negedge clk);
        ack_int = 1'b0; ack_tc = 1'b0; ack_err = 1'b0;
        chk({tag, "/flags_cleared"}, {dma_int, tc, adma_err}, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
    endtask

    // Reference: walk the table by the descriptor rules, listing fetches and offers.
    task automatic model_walk(input logic [63:0] b);
        logic [63:0] p, line;
        offer_t o;
        int links = 0;
        exp_offers.delete(); exp_fetch.delete();
        p = b; e_tc = 0; e_int = 0; e_err = 0; e_es = 2'b00;
        for (int s = 0; s < 200; s++) begin
            line = mem.exists(p) ? mem[p] : 64'h0;
            exp_fetch.push_back(p);
            if (!line[0]) begin e_err = 1; e_es = 2'b01; break; end
            if (line[5:4] == 2'b10) begin
                links = 0;
                o.addr = {32'h0, line[63:32]};
                o.len  = (line[31:16] == 16'h0) ? 17'h10000 : {1'b0, line[31:16]};
                o.last = line[1];
                exp_offers.push_back(o);
                p = p + 64'd8;
                e_int |= line[2];
                if (line[1]) begin e_tc = 1; break; end
                continue;
            end
`ifdef ADMA_LINK_LIMIT_EN
            links++;
            if (links >= MAX_LINKS) begin e_err = 1; e_es = 2'b01; break; end
`endif
            if (line[5:4] == 2'b11) begin
                if (line[34:32] != 3'b000) begin e_err = 1; e_es = 2'b01; break; end
                p = {32'h0, line[63:32]};
            end else begin
                p = p + 64'd8;
            end
            e_int |= line[2];
            if (line[1]) begin e_tc = 1; break; end
        end
        e_ptr = p;
    endtask

    task automatic run_walk(input logic [63:0] b, input string tag);
        model_walk(b);
        kick(b);
        wait_idle(600, tag);
        chk({tag, "/fetch_cnt"}, fetch_log.size(), exp_fetch.size());
        for (int i = 0; i < fetch_log.size() && i < exp_fetch.size(); i++)
            chk({tag, "/fetch_addr"}, fetch_log[i], exp_fetch[i]);
        chk({tag, "/offer_cnt"}, got.size(), exp_offers.size());
        for (int i = 0; i < got.size() && i < exp_offers.size(); i++) begin
            chk({tag, "/xfer_addr"}, got[i].addr, exp_offers[i].addr);
            chk({tag, "/xfer_len"}, got[i].len, exp_offers[i].len);
            chk({tag, "/xfer_last"}, got[i].last, exp_offers[i].last);
        end
        chk({tag, "/flags"}, {dma_int, tc, adma_err}, {e_int, e_tc, e_err});
        if (e_err) chk({tag, "/err_state"}, es, e_es);
        chk({tag, "/pointer"}, ptr, e_ptr);
        chk({tag, "/offer_stable"}, unstable, 0);
        clear_flags(tag);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{"single_tran", 64'h1000, 64'h0000_2000_0200_0027, 64'h0, 0, -1,
                    1, 64'h2000, 17'd512, 1, 1, 1, 0, 2'b00, 64'h1008};
        vecs[1] = '{"len0_hold5", 64'h1000, 64'h0000_2000_0000_0023, 64'h0, 0, 5,
                    1, 64'h2000, 17'h10000, 1, 1, 0, 0, 2'b00, 64'h1008};
        vecs[2] = '{"invalid", 64'h1000, 64'h0000_2000_0200_0026, 64'h0, 0, -1,
                    0, 64'h0, 17'd0, 0, 0, 0, 1, 2'b01, 64'h1000};
        vecs[3] = '{"nop_int_tran", 64'h1000, 64'h0000_0000_0000_0005, 64'h0000_4000_0010_0023, 0, -1,
                    1, 64'h4000, 17'd16, 1, 1, 1, 0, 2'b00, 64'h1010};
        vecs[4] = '{"rsv_end", 64'h1000, 64'h0000_0000_0000_0013, 64'h0, 0, -1,
                    0, 64'h0, 17'd0, 0, 1, 0, 0, 2'b00, 64'h1008};
        vecs[5] = '{"link_misalign", 64'h1000, 64'h0000_3004_0000_0031, 64'h0, 0, -1,
                    0, 64'h0, 17'd0, 0, 0, 0, 1, 2'b01, 64'h1000};
        vecs[6] = '{"link_end", 64'h1000, 64'h0000_3000_0000_0033, 64'h0, 0, -1,
                    0, 64'h0, 17'd0, 0, 1, 0, 0, 2'b00, 64'h3000};
        vecs[7] = '{"ptr_wrap", 64'hFFFF_FFFF_FFFF_FFF8, 64'h0000_0000_0000_0001, 64'h0000_5000_0008_0023, 0, -1,
                    1, 64'h5000, 17'd8, 1, 1, 0, 0, 2'b00, 64'h8};
        vecs[8] = '{"max_len_addr", 64'h1000, 64'hFFFF_FFF8_FFFF_0023, 64'h0, 0, -1,
                    1, 64'hFFFF_FFF8, 17'd65535, 1, 1, 0, 0, 2'b00, 64'h1008};
        vecs[9] = '{"bus_err", 64'h1000, 64'h0000_2000_0200_0027, 64'h0, 1, -1,
                    0, 64'h0, 17'd0, 0, 0, 0, 1, 2'b01, 64'h1000};

        #2 reset_n = 1'b0;
        @(negedge clk);
        chk("reset/outputs", {mem_rd_req, xfer_valid, xfer_last, busy, dma_int, tc, adma_err, es}, 0);
        chk("reset/pointer", ptr, 0);
        chk("reset/xfer_addr_len", {xfer_addr, 15'h0, xfer_len}, 0);
        @(negedge clk); reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            vec_t v;
            v = vecs[i];
            mem.delete();
            mem[v.base] = v.line0;
            if (v.line1 != 64'h0) mem[v.base + 64'd8] = v.line1;
            err_en = v.rd_err; err_addr = v.base; hold_fixed = v.hold;
            kick(v.base);
            wait_idle(300, v.name);
            chk({v.name, "/offer_cnt"}, got.size(), v.exp_offer);
            if (got.size() > 0) begin
                chk({v.name, "/xfer_addr"}, got[0].addr, v.exp_addr);
                chk({v.name, "/xfer_len"}, got[0].len, v.exp_len);
                chk({v.name, "/xfer_last"}, got[0].last, v.exp_last);
            end
            chk({v.name, "/offer_stable"}, unstable, 0);
            chk({v.name, "/flags"}, {dma_int, tc, adma_err}, {v.exp_int, v.exp_tc, v.exp_err});
            if (v.exp_err) chk({v.name, "/err_state"}, es, v.exp_es);
            chk({v.name, "/pointer"}, ptr, v.exp_ptr);
            chk({v.name, "/busy"}, busy, 0);
            clear_flags(v.name);
            err_en = 1'b0; hold_fixed = -1;
        end

        // Link then transfer: second fetch follows the link.
        mem.delete();
        mem[64'h1000] = 64'h0000_3000_0000_0031;
        mem[64'h3000] = 64'h0000_6000_0100_0023;
        run_walk(64'h1000, "link_follow");
        chk("link_follow/second_fetch", (fetch_log.size() > 1) ? fetch_log[1] : 64'h0, 64'h3000);

        // Engine error coinciding with done: error wins.
        mem.delete();
        mem[64'h1000] = 64'h0000_2000_0200_0027;
        eng_err = 1'b1; eng_done_too = 1'b1;
        kick(64'h1000);
        wait_idle(300, "xfer_err");
        chk("xfer_err/flags", {dma_int, tc, adma_err}, 3'b001);
        chk("xfer_err/err_state", es, 2'b11);
        chk("xfer_err/pointer", ptr, 64'h1000);
        clear_flags("xfer_err");
        eng_err = 1'b0; eng_done_too = 1'b0;

        // Completion set in the same cycle as its ack.
        mem[64'h1000] = 64'h0000_2000_0200_0023;
        ack_on_done = 1'b1;
        run_walk(64'h1000, "set_vs_ack");
        ack_on_done = 1'b0;

        // Reset while a fetch is outstanding.
        mem_auto = 1'b0;
        kick(64'h1000);
        chk("rst_fetch/req_before", mem_rd_req, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_fetch/outputs", {mem_rd_req, xfer_valid, xfer_last, busy, dma_int, tc, adma_err, es}, 0);
        chk("rst_fetch/pointer", ptr, 0);
        chk("rst_fetch/xfer_addr_len", {xfer_addr, 15'h0, xfer_len}, 0);
        @(negedge clk); reset_n = 1'b1; mem_auto = 1'b1;

        // Self-referencing link.
        mem.delete();
        mem[64'h1000] = 64'h0000_1000_0000_0031;
        kick(64'h1000);
`ifdef ADMA_LINK_LIMIT_EN
        wait_idle(1000, "link_loop");
        chk("link_loop/fetch_cnt", fetch_log.size(), MAX_LINKS);
        chk("link_loop/err", adma_err, 1);
        chk("link_loop/err_state", es, 2'b01);
        clear_flags("link_loop");
`else
        for (int c = 0; c < 2000 && fetch_log.size() < 100; c++) @(negedge clk);
        chk("link_loop/fetches_100", fetch_log.size() >= 100, 1);
        chk("link_loop/busy_no_err", {busy, adma_err}, 2'b10);
        apply_reset();
`endif

        for (int it = 0; it < 40; it++) begin
            logic [63:0] p, b, line, tgt;
            int n, r;
            mem.delete();
            b = {16'($urandom_range(1, 16'hFFFF)), 16'($urandom), 29'($urandom), 3'b000};
            p = b;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 9);
                line = {32'($urandom), 16'($urandom), 10'($urandom), 6'b0};
                line[0] = ($urandom_range(0, 24) != 0);
                line[1] = (k == n - 1);
                line[2] = 1'($urandom_range(0, 1));
                line[3] = 1'($urandom_range(0, 1));
                if (r < 6) begin
                    line[5:4] = 2'b10; mem[p] = line; p = p + 64'd8;
                end else if (r < 8) begin
                    line[5:4] = (r == 6) ? 2'b00 : 2'b01; mem[p] = line; p = p + 64'd8;
                end else begin
                    tgt = {32'h0, 12'(k + 1), 17'($urandom), 3'b000};
                    if ($urandom_range(0, 9) == 0) tgt[2:0] = 3'($urandom_range(1, 7));
                    line[5:4] = 2'b11; line[63:32] = tgt[31:0]; mem[p] = line; p = tgt;
                end
            end
            run_walk(b, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "watchdog");
    end
endmodule
